// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - oversampling UART receiver with a one-deep holding register.
// A frame is sampled mid-bit on ticks; completed bytes are handed off over a valid/ready handshake.
module uart_rx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 19200,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);
  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W     = $clog2(OVERSAMPLE);
  localparam int B_W     = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic                  rx_meta_q, rx_sync_q;
  logic [DIV_W-1:0]      div_cnt_q;
  logic                  tick;
  logic [S_W-1:0]        s_cnt_q, s_cnt_d;
  logic [B_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, overrun_q, overrun_d;
  logic                  frame_done, frame_ok, frame_bad;

  assign tick = (div_cnt_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      div_cnt_q   <= '0;
      s_cnt_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      div_cnt_q   <= tick ? '0 : div_cnt_q + 1'b1;
      s_cnt_q     <= s_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_bad;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (tick) begin
      case (state_q)
        IDLE: if (!rx_sync_q) begin
          state_d = START;
          s_cnt_d = '0;
        end
        // Mid-start-bit recheck rejects glitches shorter than half a bit.
        START: if (s_cnt_q == S_W'(7)) begin
          s_cnt_d   = '0;
          bit_cnt_d = '0;
          state_d   = rx_sync_q ? IDLE : DATA;
        end else begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
        DATA: if (s_cnt_q == S_W'(OVERSAMPLE - 1)) begin
          shift_d   = {rx_sync_q, shift_q[DATA_WIDTH-1:1]};
          s_cnt_d   = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == B_W'(DATA_WIDTH - 1)) state_d = STOP;
        end else begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
        STOP: if (s_cnt_q == S_W'(OVERSAMPLE - 1)) begin
          s_cnt_d = '0;
          state_d = IDLE;
        end else begin
          s_cnt_d = s_cnt_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != IDLE);
    frame_done = tick && (state_q == STOP) && (s_cnt_q == S_W'(OVERSAMPLE - 1));
    frame_ok   = frame_done && rx_sync_q;
    frame_bad  = frame_done && !rx_sync_q;
  end

  // A consume in the same cycle as a frame completion frees the slot for the new byte.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (valid_q && data_ready) valid_d = 1'b0;
    if (frame_ok) begin
      if (!valid_q || data_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - scoreboard bench for uart_rx_frame.
// Divider is scaled to 4 clk/tick so each bit spans 64 clocks.
module tb_uart_rx_frame;
  localparam int BIT_NS = 640;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b1;
  logic       frame_err, overrun, busy;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int valid_cnt = 0;
  logic busy_seen = 1'b0;
  logic prev_fe = 1'b0;
  logic prev_ov = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_frame #(
    .DATA_WIDTH(8), .BAUD_RATE(15625), .CLK_FREQ(1_000_000), .OVERSAMPLE(16)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #BIT_NS;
    end
    rx = stop_bit;
    #BIT_NS;
    rx = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every handshake, tracks flag pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_seen = 1'b1;
      if (data_valid) valid_cnt++;
      if (data_valid && data_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", data_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (data_out !== e) begin
            n_err++;
            $display("FAIL byte: got 0x%0h expected 0x%0h", data_out, e);
          end
        end
      end
      if (frame_err) begin
        fe_cnt++;
        check("frame_err_width", {31'b0, prev_fe}, 32'd0);
      end
      if (overrun) begin
        ov_cnt++;
        check("overrun_width", {31'b0, prev_ov}, 32'd0);
      end
    end
    prev_fe = frame_err;
    prev_ov = overrun;
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data_out", {24'b0, data_out}, 32'h0);
    check("rst_valid", {31'b0, data_valid}, 32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    #(2 * BIT_NS);

    exp_q.push_back(8'hCC);
    send_frame(8'hCC, 1'b1);
    #(2 * BIT_NS);
    check("cc_drained", exp_q.size(), 32'd0);
    check("cc_valid_cycles", valid_cnt, 32'd1);
    check("cc_no_frame_err", fe_cnt, 32'd0);

    busy_seen = 1'b0;
    rx = 1'b0;
    #(4 * 4 * 10);
    rx = 1'b1;
    #(2 * BIT_NS);
    check("false_start_busy_seen", {31'b0, busy_seen}, 32'd1);
    check("false_start_idle", {31'b0, busy}, 32'd0);
    check("false_start_no_valid", valid_cnt, 32'd1);
    check("false_start_no_flags", fe_cnt + ov_cnt, 32'd0);

    send_frame(8'h81, 1'b0);
    #(2 * BIT_NS);
    check("bad_stop_frame_err", fe_cnt, 32'd1);
    check("bad_stop_no_valid", valid_cnt, 32'd1);

    data_ready = 1'b0;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    send_frame(8'hA5, 1'b1);
    #BIT_NS;
    check("overrun_pulses", ov_cnt, 32'd1);
    check("held_data_out", {24'b0, data_out}, 32'h5A);
    check("held_valid", {31'b0, data_valid}, 32'd1);
    @(posedge clk);
    #1 data_ready = 1'b1;
    @(posedge clk);
    #1 data_ready = 1'b0;
    check("valid_drops_after_take", {31'b0, data_valid}, 32'd0);
    check("held_byte_popped", exp_q.size(), 32'd0);
    data_ready = 1'b1;
    #(2 * BIT_NS);

    rx = 1'b0;
    #BIT_NS;
    rx = 1'b1; #BIT_NS;
    rx = 1'b0; #BIT_NS;
    rx = 1'b1; #BIT_NS;
    #(BIT_NS / 2);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_valid", {31'b0, data_valid}, 32'd0);
    check("midrst_data_out", {24'b0, data_out}, 32'h0);
    check("midrst_flags", {30'b0, frame_err, overrun}, 32'd0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #(2 * BIT_NS);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    #(2 * BIT_NS);
    check("post_rst_drained", exp_q.size(), 32'd0);
    check("post_rst_no_frame_err", fe_cnt, 32'd1);

    valid_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    #(3 * BIT_NS);
    check("burst_drained", exp_q.size(), 32'd0);
    check("burst_valid_count", valid_cnt, 32'd10);
    check("final_frame_err_total", fe_cnt, 32'd1);
    check("final_overrun_total", ov_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame.
REQ-002 Parameter BAUD_RATE, default 19200, line rate in bit/s.
REQ-003 Parameter CLK_FREQ, default 50_000_000, clk frequency in Hz.
REQ-004 Parameter OVERSAMPLE, default 16, ticks per bit.
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 rx  input  1  asynchronous serial line; idle high.
REQ-008 data_out  output  DATA_WIDTH  received byte, holding register.
REQ-009 data_valid  output  1  data_out holds an unconsumed byte.
REQ-010 data_ready  input  1  consumer accepts data_out this cycle.
REQ-011 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 overrun  output  1  one-cycle pulse: completed byte dropped, holding register full.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer; both flops reset to 1; the FSM uses only the synchronized value.
REQ-015 Tick divider DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE), truncated, minimum 1 (defaults: 162); the counter SHALL free-run 0..DIV-1 from reset and pulse tick for one clk when it equals DIV-1.
REQ-016 The FSM SHALL have states IDLE, START, DATA and STOP; all FSM counters advance only on tick.
REQ-017 IDLE: on a tick with synchronized rx=0 -> START, s_cnt=0.
REQ-018 START: s_cnt increments per tick; at s_cnt=7, rx=0 -> DATA with s_cnt=0 and bit_cnt=0; rx=1 -> IDLE (false start, no flags).
REQ-019 DATA: at s_cnt=OVERSAMPLE-1, rx SHALL shift in LSB-first, s_cnt->0 and bit_cnt increments; after DATA_WIDTH bits -> STOP.
REQ-020 STOP: at s_cnt=OVERSAMPLE-1, rx=1 -> frame complete; rx=0 -> frame_err pulse and byte discarded; then -> IDLE in both cases.
REQ-021 On frame complete with data_valid=0 (or consumed the same cycle), data_out SHALL load the shift register and data_valid SHALL be 1 on the next cycle.
REQ-022 On frame complete with data_valid=1 and data_ready=0, the new byte SHALL be dropped, overrun SHALL pulse, and data_out SHALL stay unchanged.
REQ-023 Handshake: data_out SHALL stay stable while data_valid=1; transfer occurs on a cycle with data_valid and data_ready both high; data_valid clears the next cycle unless REQ-021 reloads.
REQ-024 Consume and frame-complete in the same cycle: the new byte loads, data_valid stays 1, no overrun.
REQ-025 data_ready SHALL be ignored while data_valid=0.
REQ-026 frame_err and overrun SHALL never be high for more than one consecutive cycle.

Reset
REQ-027 While rst=1: state=IDLE, counters=0, shift register=0, data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0, sync flops=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame without a flag; after release, the next start bit SHALL be received normally.

Verification
REQ-029 Defaults, data_ready=1, frame 0xCC (bits LSB-first 0,0,1,1,0,0,1,1, stop 1) at 52083 ns/bit -> single data_valid cycle with data_out=0xCC, frame_err=0.
REQ-030 rx low for 4 tick periods then high -> busy pulses, then IDLE; no data_valid, frame_err or overrun.
REQ-031 Frame 0x81 with stop bit 0 -> frame_err pulses once in STOP; data_valid stays 0.
REQ-032 data_ready=0; send 0x5A then 0xA5 -> data_out=0x5A held, overrun pulses once at second stop; data_ready=1 for 1 cycle -> data_valid drops next cycle.
REQ-033 rst pulse during DATA bit 3, then clean frame 0x3C -> all outputs at reset values during rst, then data_out=0x3C with data_valid.
REQ-034 10 back-to-back random bytes, data_ready=1 -> 10 data_valid pulses, bytes in order, no flags.
